// File: rtl/tlb_mp.sv
// tlb_mp: multi-port, fully associative, MIPS-style joint TLB with a CP0
// management port (TLBP/TLBR/TLBWI/TLBWR), flush, and a Random/Wired counter.
module tlb_mp #(
   parameter int unsigned ENTRIES  = 32,
   parameter int unsigned LK_PORTS = 2,
   parameter int unsigned ASID_W   = 8,
   parameter int unsigned PFN_W    = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LK_PORTS-1:0]          lk_req,
   input  logic [LK_PORTS*32-1:0]       lk_vaddr,
   input  logic [LK_PORTS-1:0]          lk_wr,
   input  logic [ASID_W-1:0]            cur_asid,
   output logic [LK_PORTS-1:0]          lk_done,
   output logic [LK_PORTS*32-1:0]       lk_paddr,
   output logic [LK_PORTS-1:0]          lk_cached,
   output logic [LK_PORTS*3-1:0]        lk_exc,
   output logic [LK_PORTS-1:0]          lk_multi,
   input  logic                         op_req,
   input  logic [1:0]                   op,
   input  logic [$clog2(ENTRIES)-1:0]   op_index,
   input  logic [31:0]                  op_entryhi,
   input  logic [31:0]                  op_entrylo0,
   input  logic [31:0]                  op_entrylo1,
   input  logic                         flush,
   input  logic [$clog2(ENTRIES)-1:0]   wired,
   input  logic                         wired_we,
   output logic                         op_ok,
   output logic [31:0]                  op_entryhi_o,
   output logic [31:0]                  op_entrylo0_o,
   output logic [31:0]                  op_entrylo1_o,
   output logic [31:0]                  op_probe,
   output logic [$clog2(ENTRIES)-1:0]   random
);
   localparam int unsigned IW = $clog2(ENTRIES);
   localparam logic [IW-1:0] TOP = IW'(ENTRIES - 1);

   typedef enum logic [1:0] {
      OP_TLBP  = 2'd0,
      OP_TLBR  = 2'd1,
      OP_TLBWI = 2'd2,
      OP_TLBWR = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      EXC_NONE      = 3'd0,
      EXC_REFILL_L  = 3'd1,
      EXC_REFILL_S  = 3'd2,
      EXC_INVALID_L = 3'd3,
      EXC_INVALID_S = 3'd4,
      EXC_MOD       = 3'd5
   } exc_e;

   typedef struct packed {
      logic [18:0]       vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [PFN_W-1:0]  pfn0;
      logic [2:0]        c0;
      logic              d0;
      logic              v0;
      logic [PFN_W-1:0]  pfn1;
      logic [2:0]        c1;
      logic              d1;
      logic              v1;
   } entry_t;

   entry_t             tlb [ENTRIES];
   logic [ENTRIES-1:0] valid;
   op_e                op_code;
   logic               write_op;
   logic [IW-1:0]      write_idx;
   entry_t             write_ent;
   entry_t             read_ent;
   logic [ENTRIES-1:0] probe_vec;
   logic               probe_hit;
   logic [IW-1:0]      probe_idx;
   logic               unused_bits;

   assign op_code     = op_e'(op);
   assign write_op    = op_req && (op_code == OP_TLBWI || op_code == OP_TLBWR);
   assign write_idx   = (op_code == OP_TLBWR) ? random : op_index;
   assign read_ent    = tlb[op_index];
   assign unused_bits = ^{op_entryhi[12:ASID_W], op_entrylo0[31:6+PFN_W], op_entrylo1[31:6+PFN_W]};

   // Unpack the CP0 EntryHi/EntryLo words into an entry; G is the AND of both halves.
   always_comb begin
      write_ent      = '0;
      write_ent.vpn2 = op_entryhi[31:13];
      write_ent.asid = op_entryhi[ASID_W-1:0];
      write_ent.g    = op_entrylo0[0] & op_entrylo1[0];
      write_ent.pfn0 = op_entrylo0[6 +: PFN_W];
      write_ent.c0   = op_entrylo0[5:3];
      write_ent.d0   = op_entrylo0[2];
      write_ent.v0   = op_entrylo0[1];
      write_ent.pfn1 = op_entrylo1[6 +: PFN_W];
      write_ent.c1   = op_entrylo1[5:3];
      write_ent.d1   = op_entrylo1[2];
      write_ent.v1   = op_entrylo1[1];
   end

   // Entry valid bits: reset and flush clear all and win over a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst || flush)  valid <= '0;
      else if (write_op) valid[write_idx] <= 1'b1;
   end

   // Entry payload; a write squashed by reset or flush leaves the old contents.
   always_ff @(posedge clk) begin
      if (!rst && !flush && write_op) tlb[write_idx] <= write_ent;
   end

   // Random counter: counts down to Wired, then reloads the top index.
   always_ff @(posedge clk) begin
      if (rst || wired_we || wired >= TOP || random == wired) random <= TOP;
      else                                                    random <= random - IW'(1);
   end

   // TLBP match vector against the EntryHi operand.
   always_comb begin
      probe_vec = '0;
      for (int unsigned i = 0; i < ENTRIES; i++)
         probe_vec[i] = valid[i] && (tlb[i].vpn2 == op_entryhi[31:13]) &&
                        (tlb[i].g || tlb[i].asid == op_entryhi[ASID_W-1:0]);
   end

   // TLBP priority pick: lowest matching index.
   always_comb begin
      probe_hit = 1'b0;
      probe_idx = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (probe_vec[i] && !probe_hit) begin
            probe_hit = 1'b1;
            probe_idx = IW'(i);
         end
      end
   end

   // Management results register; each output holds until its own op repeats.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_ok         <= 1'b0;
         op_probe      <= 32'h8000_0000;
         op_entryhi_o  <= '0;
         op_entrylo0_o <= '0;
         op_entrylo1_o <= '0;
      end else begin
         op_ok <= op_req;
         if (op_req) begin
            case (op_code)
               OP_TLBP: op_probe <= probe_hit ? {1'b0, 31'(probe_idx)} : 32'h8000_0000;
               OP_TLBR: begin
                  op_entryhi_o  <= {read_ent.vpn2, {(13-ASID_W){1'b0}},
                                    valid[op_index] ? read_ent.asid : {ASID_W{1'b0}}};
                  op_entrylo0_o <= 32'({read_ent.pfn0, read_ent.c0, read_ent.d0, read_ent.v0, read_ent.g});
                  op_entrylo1_o <= 32'({read_ent.pfn1, read_ent.c1, read_ent.d1, read_ent.v1, read_ent.g});
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar p = 0; p < LK_PORTS; p++) begin : g_port
      logic [31:0]        va;
      logic [ENTRIES-1:0] mvec;
      logic               hit;
      logic [IW-1:0]      hidx;
      entry_t             ent;
      logic               mapped;
      logic               pv;
      logic               pd;
      logic [2:0]         pc;
      logic [PFN_W-1:0]   ppfn;
      logic [31:0]        pa_n;
      logic               cached_n;
      logic               multi_n;
      exc_e               exc_n;
      logic               done_q;
      logic               cached_q;
      logic               multi_q;
      logic [31:0]        pa_q;
      exc_e               exc_q;

      assign va     = lk_vaddr[p*32 +: 32];
      assign mapped = (va[31:30] != 2'b10);
      assign ent    = tlb[hidx];

      // Per-port match vector against the current ASID.
      always_comb begin
         mvec = '0;
         for (int unsigned i = 0; i < ENTRIES; i++)
            mvec[i] = valid[i] && (tlb[i].vpn2 == va[31:13]) &&
                      (tlb[i].g || tlb[i].asid == cur_asid);
      end

      // Lowest matching index wins.
      always_comb begin
         hit  = 1'b0;
         hidx = '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (mvec[i] && !hit) begin
               hit  = 1'b1;
               hidx = IW'(i);
            end
         end
      end

      // Page select, segment decode, exception priority.
      always_comb begin
         pv       = va[12] ? ent.v1 : ent.v0;
         pd       = va[12] ? ent.d1 : ent.d0;
         pc       = va[12] ? ent.c1 : ent.c0;
         ppfn     = va[12] ? ent.pfn1 : ent.pfn0;
         exc_n    = EXC_NONE;
         multi_n  = mapped && ((mvec & (mvec - ENTRIES'(1))) != '0);
         pa_n     = mapped ? 32'({ppfn, va[11:0]}) : {3'b000, va[28:0]};
         cached_n = mapped ? (hit && pc == 3'd3) : !va[29];
         if (mapped) begin
            if (!hit)                 exc_n = lk_wr[p] ? EXC_REFILL_S  : EXC_REFILL_L;
            else if (!pv)             exc_n = lk_wr[p] ? EXC_INVALID_S : EXC_INVALID_L;
            else if (lk_wr[p] && !pd) exc_n = EXC_MOD;
         end
      end

      // Lookup result register; address and cacheability hold while idle.
      always_ff @(posedge clk) begin
         if (rst) begin
            done_q   <= 1'b0;
            exc_q    <= EXC_NONE;
            multi_q  <= 1'b0;
            pa_q     <= '0;
            cached_q <= 1'b0;
         end else begin
            done_q  <= lk_req[p];
            exc_q   <= lk_req[p] ? exc_n : EXC_NONE;
            multi_q <= lk_req[p] && multi_n;
            if (lk_req[p]) begin
               pa_q     <= pa_n;
               cached_q <= cached_n;
            end
         end
      end

      assign lk_done[p]          = done_q;
      assign lk_exc[p*3 +: 3]    = exc_q;
      assign lk_multi[p]         = multi_q;
      assign lk_paddr[p*32 +: 32] = pa_q;
      assign lk_cached[p]        = cached_q;
   end

endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: directed and randomized checks of tlb_mp against a behavioural model.
module tb_tlb_mp;
   logic        clk;
   logic        rst;
   logic [1:0]  lk_req;
   logic [31:0] va [2];
   logic [63:0] lk_vaddr;
   logic [1:0]  lk_wr;
   logic [7:0]  cur_asid;
   logic [1:0]  lk_done;
   logic [63:0] lk_paddr;
   logic [1:0]  lk_cached;
   logic [5:0]  lk_exc;
   logic [1:0]  lk_multi;
   logic        op_req;
   logic [1:0]  op;
   logic [4:0]  op_index;
   logic [31:0] op_entryhi, op_entrylo0, op_entrylo1;
   logic        flush;
   logic [4:0]  wired;
   logic        wired_we;
   logic        op_ok;
   logic [31:0] op_entryhi_o, op_entrylo0_o, op_entrylo1_o, op_probe;
   logic [4:0]  random;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] m_hi [32];
   logic [31:0] m_lo0 [32];
   logic [31:0] m_lo1 [32];
   logic [31:0] m_e;
   logic [4:0]  m_rand;
   logic [18:0] pool [8];

   // expected outputs
   logic        exp_done [2];
   logic [31:0] exp_pa [2];
   logic        exp_cached [2];
   logic [2:0]  exp_exc [2];
   logic        exp_multi [2];
   logic        exp_ok;
   logic [31:0] exp_probe, exp_hi, exp_lo0, exp_lo1;

   assign lk_vaddr = {va[1], va[0]};

   tlb_mp #(.ENTRIES(32), .LK_PORTS(2), .ASID_W(8), .PFN_W(20)) dut (
      .clk(clk), .rst(rst), .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_wr(lk_wr),
      .cur_asid(cur_asid), .lk_done(lk_done), .lk_paddr(lk_paddr), .lk_cached(lk_cached),
      .lk_exc(lk_exc), .lk_multi(lk_multi), .op_req(op_req), .op(op), .op_index(op_index),
      .op_entryhi(op_entryhi), .op_entrylo0(op_entrylo0), .op_entrylo1(op_entrylo1),
      .flush(flush), .wired(wired), .wired_we(wired_we), .op_ok(op_ok),
      .op_entryhi_o(op_entryhi_o), .op_entrylo0_o(op_entrylo0_o),
      .op_entrylo1_o(op_entrylo1_o), .op_probe(op_probe), .random(random)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CP0 Random as described architecturally: count down, reload at Wired.
   always @(posedge clk) begin
      if (rst || wired_we || wired >= 5'd31 || m_rand == wired) m_rand <= 5'd31;
      else                                                     m_rand <= m_rand - 5'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_lookup(input logic [31:0] a, input logic w, input logic [7:0] asid,
                                        output logic [31:0] pa, output logic c,
                                        output logic [2:0] ex, output logic m);
      int hit = -1;
      int cnt = 0;
      logic [31:0] lo;
      pa = '0; c = 1'b0; ex = 3'd0; m = 1'b0;
      if (a >= 32'h8000_0000 && a < 32'hC000_0000) begin
         pa = a - ((a < 32'hA000_0000) ? 32'h8000_0000 : 32'hA000_0000);
         c  = (a < 32'hA000_0000);
         return;
      end
      for (int i = 0; i < 32; i++) begin
         if (m_e[i] && m_hi[i][31:13] == a[31:13] && (m_lo0[i][0] || m_hi[i][7:0] == asid)) begin
            cnt++;
            if (hit < 0) hit = i;
         end
      end
      m = (cnt > 1);
      if (hit < 0) begin
         ex = w ? 3'd2 : 3'd1;
         return;
      end
      lo = a[12] ? m_lo1[hit] : m_lo0[hit];
      pa = {lo[25:6], a[11:0]};
      c  = (lo[5:3] == 3'd3);
      if (!lo[1])           ex = w ? 3'd4 : 3'd3;
      else if (w && !lo[2]) ex = 3'd5;
   endfunction

   task automatic idle();
      rst = 1'b0; lk_req = 2'b00; lk_wr = 2'b00; op_req = 1'b0; op = 2'd0;
      flush = 1'b0; wired_we = 1'b0; va[0] = '0; va[1] = '0;
   endtask

   // One clock: predict from model state before the edge, update model, then compare.
   task automatic cycle();
      logic [31:0] pa;
      logic        c, m, g, was_rst;
      logic [2:0]  ex;
      int          hit;
      int          widx;
      was_rst = rst;
      for (int p = 0; p < 2; p++) begin
         if (rst) begin
            exp_done[p] = 1'b0; exp_exc[p] = 3'd0; exp_multi[p] = 1'b0;
            exp_pa[p] = '0; exp_cached[p] = 1'b0;
         end else begin
            exp_done[p] = lk_req[p];
            exp_exc[p] = 3'd0; exp_multi[p] = 1'b0;
            if (lk_req[p]) begin
               model_lookup(va[p], lk_wr[p], cur_asid, pa, c, ex, m);
               exp_pa[p] = pa; exp_cached[p] = c; exp_exc[p] = ex; exp_multi[p] = m;
            end
         end
      end
      if (rst) begin
         exp_ok = 1'b0; exp_probe = 32'h8000_0000; exp_hi = '0; exp_lo0 = '0; exp_lo1 = '0;
      end else begin
         exp_ok = op_req;
         if (op_req && op == 2'd0) begin
            hit = -1;
            for (int i = 0; i < 32; i++)
               if (hit < 0 && m_e[i] && m_hi[i][31:13] == op_entryhi[31:13] &&
                   (m_lo0[i][0] || m_hi[i][7:0] == op_entryhi[7:0])) hit = i;
            exp_probe = (hit < 0) ? 32'h8000_0000 : 32'(hit);
         end
         if (op_req && op == 2'd1) begin
            exp_hi  = m_e[op_index] ? m_hi[op_index] : {m_hi[op_index][31:8], 8'h00};
            exp_lo0 = m_lo0[op_index];
            exp_lo1 = m_lo1[op_index];
         end
      end
      if (!rst && !flush && op_req && op[1]) begin
         widx = (op == 2'd3) ? int'(m_rand) : int'(op_index);
         g = op_entrylo0[0] & op_entrylo1[0];
         m_hi[widx]  = {op_entryhi[31:13], 5'b0, op_entryhi[7:0]};
         m_lo0[widx] = {6'b0, op_entrylo0[25:1], g};
         m_lo1[widx] = {6'b0, op_entrylo1[25:1], g};
         m_e[widx]   = 1'b1;
      end
      if (rst || flush) m_e = '0;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         chk("lk_done", 32'(lk_done[p]), 32'(exp_done[p]));
         chk("lk_exc", 32'(lk_exc[p*3 +: 3]), 32'(exp_exc[p]));
         chk("lk_multi", 32'(lk_multi[p]), 32'(exp_multi[p]));
         if (was_rst || (exp_done[p] && exp_exc[p] == 3'd0)) begin
            chk("lk_paddr", lk_paddr[p*32 +: 32], exp_pa[p]);
            chk("lk_cached", 32'(lk_cached[p]), 32'(exp_cached[p]));
         end
      end
      chk("op_ok", 32'(op_ok), 32'(exp_ok));
      chk("op_probe", op_probe, exp_probe);
      chk("op_entryhi_o", op_entryhi_o, exp_hi);
      chk("op_entrylo0_o", op_entrylo0_o, exp_lo0);
      chk("op_entrylo1_o", op_entrylo1_o, exp_lo1);
      chk("random", 32'(random), 32'(m_rand));
   endtask

   task automatic mgmt(input logic [1:0] o, input logic [4:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
      op_req = 1'b1; op = o; op_index = idx;
      op_entryhi = hi; op_entrylo0 = lo0; op_entrylo1 = lo1;
   endtask

   initial begin
      logic [31:0] r;
      wired = 5'd0; cur_asid = 8'd0; op_index = '0;
      op_entryhi = '0; op_entrylo0 = '0; op_entrylo1 = '0;
      idle();

      // reset with requests pending: everything dropped
      rst = 1'b1; lk_req = 2'b11; va[0] = 32'h0040_0000; mgmt(2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      cycle();
      cycle();
      chk("rst_done", 32'(lk_done), 32'd0);
      chk("rst_probe", op_probe, 32'h8000_0000);
      chk("rst_random", 32'(random), 32'd31);

      // lookup after reset misses; TLBP misses
      idle(); lk_req = 2'b01; va[0] = 32'h0040_0000; cur_asid = 8'd3;
      mgmt(2'd0, 5'd0, 32'h0040_0003, 32'h0, 32'h0);
      cycle();
      chk("reset_refill", 32'(lk_exc[2:0]), 32'd1);
      chk("reset_probe_miss", op_probe, 32'h8000_0000);

      // write index 5 then hit / modified / asid mismatch
      idle(); mgmt(2'd2, 5'd5, 32'h0040_0003, 32'h0048_D15A, 32'h0); cycle();
      idle(); lk_req = 2'b01; va[0] = 32'h0040_0ABC; cycle();
      chk("hit_paddr", lk_paddr[31:0], 32'h1234_5ABC);
      chk("hit_cached", 32'(lk_cached[0]), 32'd1);
      chk("hit_exc", 32'(lk_exc[2:0]), 32'd0);
      idle(); lk_req = 2'b01; lk_wr = 2'b01; va[0] = 32'h0040_0ABC; cycle();
      chk("modified", 32'(lk_exc[2:0]), 32'd5);
      idle(); lk_req = 2'b01; va[0] = 32'h0040_0ABC; cur_asid = 8'd4; cycle();
      chk("asid_miss", 32'(lk_exc[2:0]), 32'd1);

      // unmapped segments on both ports at once
      idle(); lk_req = 2'b11; va[0] = 32'h8000_1000; va[1] = 32'hBFC0_0000; cycle();
      chk("kseg0_pa", lk_paddr[31:0], 32'h0000_1000);
      chk("kseg0_c", 32'(lk_cached[0]), 32'd1);
      chk("kseg1_pa", lk_paddr[63:32], 32'h1FC0_0000);
      chk("kseg1_c", 32'(lk_cached[1]), 32'd0);
      chk("kseg_done", 32'(lk_done), 32'd3);

      // write versus lookup at the same edge, then one cycle later
      cur_asid = 8'd3;
      idle(); lk_req = 2'b01; va[0] = 32'h0100_0010;
      mgmt(2'd2, 5'd7, 32'h0100_0003, 32'h0002_AF16, 32'h0); cycle();
      chk("hazard_old", 32'(lk_exc[2:0]), 32'd1);
      idle(); lk_req = 2'b01; va[0] = 32'h0100_0010; cycle();
      chk("hazard_new", 32'(lk_exc[2:0]), 32'd0);
      chk("hazard_pa", lk_paddr[31:0], 32'h00AB_C010);

      // multi-hit: same VPN2 in entries 2 and 9
      idle(); mgmt(2'd2, 5'd2, 32'h0060_0001, 32'h0000_889F, 32'h1); cycle();
      idle(); mgmt(2'd2, 5'd9, 32'h0060_0001, 32'h0002_665F, 32'h1); cycle();
      idle(); lk_req = 2'b01; va[0] = 32'h0060_0004; mgmt(2'd0, 5'd0, 32'h0060_0000, 32'h0, 32'h0); cycle();
      chk("multi", 32'(lk_multi[0]), 32'd1);
      chk("multi_pa", lk_paddr[31:0], 32'h0022_2004);
      chk("multi_probe", op_probe, 32'd2);

      // TLBR of index 5
      idle(); mgmt(2'd1, 5'd5, 32'h0, 32'h0, 32'h0); cycle();
      chk("tlbr_hi", op_entryhi_o, 32'h0040_0003);
      chk("tlbr_lo0", op_entrylo0_o, 32'h0048_D15A);

      // Random / Wired
      idle(); wired = 5'd4; wired_we = 1'b1; cycle();
      chk("rand_load", 32'(random), 32'd31);
      idle();
      for (int k = 1; k <= 27; k++) begin
         cycle();
         chk("rand_seq", 32'(random), 32'(31 - k));
      end
      cycle();
      chk("rand_wrap", 32'(random), 32'd31);
      for (int k = 0; k < 14; k++) cycle();
      chk("rand_17", 32'(random), 32'd17);
      idle(); mgmt(2'd3, 5'd0, 32'h0080_0005, 32'h0155_555F, 32'h0199_999F); cycle();
      idle(); mgmt(2'd1, 5'd17, 32'h0, 32'h0, 32'h0); cycle();
      chk("tlbwr_hi", op_entryhi_o, 32'h0080_0005);
      chk("tlbwr_lo0", op_entrylo0_o, 32'h0155_555F);
      chk("tlbwr_lo1", op_entrylo1_o, 32'h0199_999F);
      idle(); wired = 5'd31; wired_we = 1'b1; cycle();
      idle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("rand_hold", 32'(random), 32'd31);
      end
      idle(); wired = 5'd0; wired_we = 1'b1; cycle();

      // flush, and flush beating a same-cycle write
      idle(); flush = 1'b1; cycle();
      idle(); lk_req = 2'b11; va[0] = 32'h0040_0ABC; va[1] = 32'h0100_0010; cycle();
      chk("flush_p0", 32'(lk_exc[2:0]), 32'd1);
      chk("flush_p1", 32'(lk_exc[5:3]), 32'd1);
      idle(); flush = 1'b1; mgmt(2'd2, 5'd5, 32'h0040_0003, 32'h0048_D15A, 32'h0); cycle();
      idle(); lk_req = 2'b01; va[0] = 32'h0040_0ABC; cycle();
      chk("flush_wr", 32'(lk_exc[2:0]), 32'd1);

      // randomized phase: fill every entry, then mixed traffic
      for (int i = 0; i < 8; i++) begin
         r = $urandom();
         pool[i] = (i < 6) ? {1'b0, r[17:0]} : {2'b11, r[16:0]};
      end
      for (int i = 0; i < 32; i++) begin
         idle();
         r = $urandom();
         mgmt(2'd2, 5'(i), {pool[r[2:0]], 5'd0, 6'd0, r[4:3]}, $urandom(), $urandom());
         cycle();
      end
      for (int n = 0; n < 600; n++) begin
         idle();
         rst      = ($urandom_range(0, 199) == 0);
         flush    = ($urandom_range(0, 49) == 0);
         wired_we = ($urandom_range(0, 29) == 0);
         if (wired_we) wired = 5'($urandom_range(0, 31));
         cur_asid = 8'($urandom_range(0, 3));
         lk_req   = 2'($urandom_range(0, 3));
         lk_wr    = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            r = $urandom();
            case ($urandom_range(0, 7))
               5:       va[p] = {3'b100, r[28:0]};
               6:       va[p] = {3'b101, r[28:0]};
               default: va[p] = {pool[$urandom_range(0, 7)], r[12:0]};
            endcase
         end
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom();
            mgmt(2'(r[1:0]), 5'(r[6:2]), {pool[r[9:7]], r[14:10], 6'd0, r[16:15]},
                 $urandom(), $urandom());
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tlb_mp.md
# tlb_mp

Parametrised, multi-port, fully associative MIPS-style joint TLB. It serves `LK_PORTS` independent registered lookup ports (instruction fetch, load/store, ...) plus one CP0 management port (TLBP/TLBR/TLBWI/TLBWR/flush). Compared with the previous single-I/D TLB it adds:

- reset-time and flush-driven invalidation;
- an internal Random/Wired replacement counter;
- multi-hit detection;
- defined write-versus-lookup ordering.

It sits between the pipeline address-generation stages and the cache/bus interfaces.

## Interface
Parameters:
- `ENTRIES`, 32: number of TLB entries, power of two, 4..64; `IW = $clog2(ENTRIES)`.
- `LK_PORTS`, 2: number of independent lookup ports.
- `ASID_W`, 8: ASID width.
- `PFN_W`, 20: PFN width; physical address = `{PFN, vaddr[11:0]}` truncated or zero-extended to 32 bits.

Ports:
- `clk`  in  1  clock, all state on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lk_req`  in  `LK_PORTS`  lookup request, one bit per port.
- `lk_vaddr`  in  `LK_PORTS*32`  virtual addresses, packed, port 0 in the LSBs.
- `lk_wr`  in  `LK_PORTS`  access is a store.
- `cur_asid`  in  `ASID_W`  current EntryHi.ASID, shared by all ports.
- `lk_done`  out  `LK_PORTS`  result valid, registered.
- `lk_paddr`  out  `LK_PORTS*32`  translated physical address.
- `lk_cached`  out  `LK_PORTS`  1 = cacheable: kseg0, or a mapped page with C == 3.
- `lk_exc`  out  `LK_PORTS*3`  exception code: 0 none, 1 REFILL_L, 2 REFILL_S, 3 INVALID_L, 4 INVALID_S, 5 MODIFIED.
- `lk_multi`  out  `LK_PORTS`  more than one entry matched.
- `op_req`  in  1  management op request, single-cycle pulse.
- `op`  in  2  0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR.
- `op_index`  in  `IW`  CP0 Index, used by TLBR/TLBWI.
- `op_entryhi`  in  32  `{VPN2[31:13], 0, ASID}`.
- `op_entrylo0`, `op_entrylo1`  in  32 each  `{0, PFN[25:6], C[5:3], D, V, G}`.
- `flush`  in  1  invalidate all entries.
- `wired`  in  `IW`  CP0 Wired.
- `wired_we`  in  1  Wired being written this cycle.
- `op_ok`  out  1  management op complete, 1-cycle pulse.
- `op_entryhi_o`, `op_entrylo0_o`, `op_entrylo1_o`  out  32 each  TLBR result.
- `op_probe`  out  32  TLBP result: `{miss, 0, index}`.
- `random`  out  `IW`  CP0 Random.

## Operation
- **Entry state.** Each entry holds VPN2, ASID, G, a valid bit `E`, and PFN/C/D/V for each of page 0 and page 1.
- **Match rule.** An entry matches when `E` is set, VPN2 equals `vaddr[31:13]`, and either G is set or the entry ASID equals `cur_asid`. For TLBP, VPN2 and ASID are taken from `op_entryhi`.
- **Page select.** `vaddr[12]` selects page 0 or page 1.
- **Segments** (per port):
  - `<0x8000_0000` and `>=0xC000_0000`: mapped.
  - kseg0: `paddr = vaddr - 0x8000_0000`, cached.
  - kseg1: `paddr = vaddr - 0xA000_0000`, uncached.
  - Unmapped accesses never raise an exception.
- **Exception priority** (mapped, `lk_req` = 1):
  - no match: REFILL_L or REFILL_S (by `lk_wr`);
  - else V = 0: INVALID_L or INVALID_S;
  - else `lk_wr` and D = 0: MODIFIED;
  - else none.
- **Multi-hit.** The lowest matching index wins and `lk_multi` is set. TLBP also reports the lowest matching index.
- **TLBWI / TLBWR.** Write `op_index` or `random` respectively. Stored G = `lo0.G & lo1.G`, and `E` is set.
- **TLBR.** Returns the entry with both G fields equal to the stored G, and ASID zeroed when `E` = 0.
- **Random counter.**
  - Reset value: `ENTRIES-1`.
  - Decrements every cycle.
  - When it equals `wired` it reloads `ENTRIES-1` on the next cycle.
  - When `wired_we` = 1 it reloads `ENTRIES-1`.
  - If `wired >= ENTRIES-1`, it holds at `ENTRIES-1`.
- **Flush.** `flush` clears every `E`; it takes priority over a same-cycle write.
- **Reset.** `rst` clears every `E` and sets `random` to `ENTRIES-1`. All outputs go to 0 except `op_probe = 0x8000_0000` and `random = ENTRIES-1`.

## Timing
- **Lookup.** Latency 1: inputs sampled at edge N, results on `lk_*` from edge N+1.
  - `lk_done` = registered `lk_req`; no backpressure.
  - Ports are fully independent and may all request every cycle.
  - With `lk_done` = 0, `lk_exc` = 0 and `lk_multi` = 0; `lk_paddr` holds its previous value.
- **Management.** `op_req` sampled at edge N; `op_ok` pulses at N+1 with the result outputs valid at N+1; those outputs hold until the next op.
  - Writes update the array at edge N.
  - A lookup or TLBP sampled at the same edge N sees the old contents.
  - A lookup sampled at N+1 sees the new contents.
  - Back-to-back `op_req` every cycle is legal.
- **TLBWR** uses the `random` value present at edge N.
- **Reset mid-operation.** Pending `lk_done` and `op_ok` are dropped; the cycle after `rst` deasserts, all outputs are at their reset values.

## Test plan
- **Reset then lookup:** after `rst`, lookup at vaddr 0x0040_0000, `lk_wr` = 0 -> `lk_exc` = 1 (REFILL_L) one cycle later; TLBP on the same VPN2 -> `op_probe` = 0x8000_0000.
- **Write then lookup:**
  - TLBWI index 5 with VPN2 0x00200, ASID 3, lo0 PFN 0x12345, V = 1, D = 0, C = 3.
  - Load at 0x0040_0ABC, ASID 3 -> paddr 0x1234_5ABC, cached, exc 0.
  - Store at the same address -> exc 5 (MODIFIED).
  - Same load with ASID 4 -> exc 1.
- **Segments:** port 0 at 0x8000_1000 gives paddr 0x0000_1000, cached, done with no exception; port 1 at 0xBFC0_0000 gives paddr 0x1FC0_0000, uncached — both in the same cycle.
- **Write/lookup hazard and multi-hit:**
  - TLBWI and a lookup of the same address at the same edge -> REFILL.
  - The same lookup one cycle later -> hit.
  - Write the same VPN2 to indices 2 and 9 -> `lk_multi` = 1, and TLBP returns index 2.
- **Random / Wired:**
  - `wired` = 4 with `wired_we` -> `random` sequence 31, 30, ..., 4, 31.
  - TLBWR while `random` = 17 -> TLBR index 17 returns the written entry.
- **Flush:** after `flush`, every previously hitting address -> REFILL. `flush` with a simultaneous TLBWI -> the written entry is also invalid.
